// File: rtl/nd_2to1_arb.sv
// nd_2to1_arb: two-input, one-output message arbiter.
// Every channel uses a 4-phase req/ack handshake. A granted message is copied
// into a holding register and forwarded on snd0. When both inputs contend,
// the round-robin pointer chooses the winner.

`ifndef NS_ADDRESS_SIZE
`define NS_ADDRESS_SIZE 8
`endif
`ifndef NS_DATA_SIZE
`define NS_DATA_SIZE 16
`endif
`ifndef NS_REDUN_SIZE
`define NS_REDUN_SIZE 4
`endif

module nd_2to1_arb #(
    parameter int ASZ = `NS_ADDRESS_SIZE,
    parameter int DSZ = `NS_DATA_SIZE,
    parameter int RSZ = `NS_REDUN_SIZE
) (
    input  logic           i_clk,
    input  logic           reset,
    output logic           ready,

    input  logic [ASZ-1:0] rcv0_src,
    input  logic [ASZ-1:0] rcv0_dst,
    input  logic [DSZ-1:0] rcv0_dat,
    input  logic [RSZ-1:0] rcv0_red,
    input  logic           rcv0_req,
    output logic           rcv0_ack,

    input  logic [ASZ-1:0] rcv1_src,
    input  logic [ASZ-1:0] rcv1_dst,
    input  logic [DSZ-1:0] rcv1_dat,
    input  logic [RSZ-1:0] rcv1_red,
    input  logic           rcv1_req,
    output logic           rcv1_ack,

    output logic [ASZ-1:0] snd0_src,
    output logic [ASZ-1:0] snd0_dst,
    output logic [DSZ-1:0] snd0_dat,
    output logic [RSZ-1:0] snd0_red,
    output logic           snd0_req,
    input  logic           snd0_ack
);

    typedef enum logic [1:0] {IDLE, TAKE, SEND, DONE} state_t;

    state_t         state, state_nx;
    logic           prio, prio_nx;
    logic           win, win_nx;
    logic           ack0_nx, ack1_nx, sreq_nx;
    logic [ASZ-1:0] src_nx, dst_nx;
    logic [DSZ-1:0] dat_nx;
    logic [RSZ-1:0] red_nx;
    logic           take0, take1, grant1, win_req;

    // A channel is eligible when it requests and has no ack outstanding.
    // Channel 1 wins if it is the only requester, or if both request and
    // the pointer currently favours it.
    assign take0   = rcv0_req & ~rcv0_ack;
    assign take1   = rcv1_req & ~rcv1_ack;
    assign grant1  = take1 & (~take0 | prio);
    assign win_req = win ? rcv1_req : rcv0_req;

    // ready rises on the first clock edge after reset is released.
    always_ff @(posedge i_clk or posedge reset) begin
        if (reset) ready <= 1'b0;
        else       ready <= 1'b1;
    end

    // State register, handshake outputs and holding register.
    always_ff @(posedge i_clk or posedge reset) begin
        if (reset) begin
            state    <= IDLE;
            prio     <= 1'b0;
            win      <= 1'b0;
            rcv0_ack <= 1'b0;
            rcv1_ack <= 1'b0;
            snd0_req <= 1'b0;
            snd0_src <= '0;
            snd0_dst <= '0;
            snd0_dat <= '0;
            snd0_red <= '0;
        end else begin
            state    <= state_nx;
            prio     <= prio_nx;
            win      <= win_nx;
            rcv0_ack <= ack0_nx;
            rcv1_ack <= ack1_nx;
            snd0_req <= sreq_nx;
            snd0_src <= src_nx;
            snd0_dst <= dst_nx;
            snd0_dat <= dat_nx;
            snd0_red <= red_nx;
        end
    end

    // Next-state and next-output logic for the handshake sequence.
    always_comb begin
        state_nx = state;
        prio_nx  = prio;
        win_nx   = win;
        ack0_nx  = rcv0_ack;
        ack1_nx  = rcv1_ack;
        sreq_nx  = snd0_req;
        src_nx   = snd0_src;
        dst_nx   = snd0_dst;
        dat_nx   = snd0_dat;
        red_nx   = snd0_red;
        case (state)
            IDLE: begin
                if (ready && (take0 || take1)) begin
                    win_nx = grant1;
                    if (grant1) begin
                        src_nx  = rcv1_src;
                        dst_nx  = rcv1_dst;
                        dat_nx  = rcv1_dat;
                        red_nx  = rcv1_red;
                        ack1_nx = 1'b1;
                    end else begin
                        src_nx  = rcv0_src;
                        dst_nx  = rcv0_dst;
                        dat_nx  = rcv0_dat;
                        red_nx  = rcv0_red;
                        ack0_nx = 1'b1;
                    end
                    state_nx = TAKE;
                end
            end
            TAKE: begin
                if (!win_req) begin
                    ack0_nx  = 1'b0;
                    ack1_nx  = 1'b0;
                    sreq_nx  = 1'b1;
                    state_nx = SEND;
                end
            end
            SEND: begin
                if (snd0_ack) begin
                    sreq_nx  = 1'b0;
                    state_nx = DONE;
                end
            end
            DONE: begin
                if (!snd0_ack) begin
                    prio_nx  = ~win;
                    state_nx = IDLE;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

endmodule

// File: tb/tb_nd_2to1_arb.sv
// Self-checking bench for nd_2to1_arb. Directed scenarios run first,
// followed by a randomized message stream that is compared against a
// transaction-level arbitration model.

module tb_nd_2to1_arb;

    typedef struct packed {
        logic [7:0]  src;
        logic [7:0]  dst;
        logic [15:0] dat;
        logic [3:0]  red;
    } msg_t;

    logic        i_clk = 1'b0;
    logic        reset = 1'b1;
    logic        ready;
    logic [7:0]  rcv0_src = '0, rcv0_dst = '0, rcv1_src = '0, rcv1_dst = '0;
    logic [15:0] rcv0_dat = '0, rcv1_dat = '0;
    logic [3:0]  rcv0_red = '0, rcv1_red = '0;
    logic        rcv0_req = 1'b0, rcv1_req = 1'b0, snd0_ack = 1'b0;
    logic        rcv0_ack, rcv1_ack, snd0_req;
    logic [7:0]  snd0_src, snd0_dst;
    logic [15:0] snd0_dat;
    logic [3:0]  snd0_red;

    int errors = 0;
    int checks = 0;

    nd_2to1_arb #(.ASZ(8), .DSZ(16), .RSZ(4)) dut (
        .i_clk(i_clk), .reset(reset), .ready(ready),
        .rcv0_src(rcv0_src), .rcv0_dst(rcv0_dst), .rcv0_dat(rcv0_dat),
        .rcv0_red(rcv0_red), .rcv0_req(rcv0_req), .rcv0_ack(rcv0_ack),
        .rcv1_src(rcv1_src), .rcv1_dst(rcv1_dst), .rcv1_dat(rcv1_dat),
        .rcv1_red(rcv1_red), .rcv1_req(rcv1_req), .rcv1_ack(rcv1_ack),
        .snd0_src(snd0_src), .snd0_dst(snd0_dst), .snd0_dat(snd0_dat),
        .snd0_red(snd0_red), .snd0_req(snd0_req), .snd0_ack(snd0_ack)
    );

    always #5 i_clk = ~i_clk;

    task automatic tick();
        @(posedge i_clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic msg_t rnd();
        msg_t m;
        m.src = 8'($urandom);
        m.dst = 8'($urandom);
        m.dat = 16'($urandom);
        m.red = 4'($urandom);
        return m;
    endfunction

    function automatic msg_t snd_msg();
        return {snd0_src, snd0_dst, snd0_dat, snd0_red};
    endfunction

    task automatic set_rcv(input int ch, input msg_t m, input logic r);
        if (ch == 0) begin
            {rcv0_src, rcv0_dst, rcv0_dat, rcv0_red} = m;
            rcv0_req = r;
        end else begin
            {rcv1_src, rcv1_dst, rcv1_dat, rcv1_red} = m;
            rcv1_req = r;
        end
    endtask

    // Entered with channel ch already acknowledged; completes the transfer
    // and returns with the arbiter back in IDLE.
    task automatic serve(input int ch, input msg_t m);
        if (ch == 0) rcv0_req = 1'b0; else rcv1_req = 1'b0;
        tick();
        chk("serve_sndreq", snd0_req, 1);
        chk("serve_ack0", rcv0_ack, 0);
        chk("serve_ack1", rcv1_ack, 0);
        chk("serve_msg", snd_msg(), m);
        snd0_ack = 1'b1;
        tick();
        chk("serve_sndreq_clr", snd0_req, 0);
        snd0_ack = 1'b0;
        tick();
    endtask

    initial begin
        msg_t m0, m1, m2, m3, m4, m5, m6, m7;
        msg_t q0[$], q1[$], exp_m[$];
        int   exp_ch[$];
        msg_t cur[2];
        int   ph[2];
        msg_t cm;
        int   cw, cph, mprio, outs, cyc, w, e;
        logic busy, pr0, pr1, pa0, pa1, ackc;

        // ---- reset values
        tick();
        tick();
        chk("rst_ready", ready, 0);
        chk("rst_ack0", rcv0_ack, 0);
        chk("rst_ack1", rcv1_ack, 0);
        chk("rst_sndreq", snd0_req, 0);
        chk("rst_fields", snd_msg(), 0);
        reset = 1'b0;
        #1;
        chk("rel_ready_before_edge", ready, 0);
        tick();
        chk("rel_ready_after_edge", ready, 1);

        // ---- contention, back-pressure, round-robin
        m0 = rnd();
        m1 = rnd();
        set_rcv(0, m0, 1);
        set_rcv(1, m1, 1);
        tick();
        chk("cont_ack0", rcv0_ack, 1);
        chk("cont_ack1", rcv1_ack, 0);
        chk("cont_sndreq", snd0_req, 0);
        rcv0_req = 1'b0;
        tick();
        chk("cont_sndreq_up", snd0_req, 1);
        chk("cont_ack0_clr", rcv0_ack, 0);
        chk("cont_msg", snd_msg(), m0);
        for (int i = 0; i < 20; i++) begin
            tick();
            chk("bp_sndreq", snd0_req, 1);
            chk("bp_msg", snd_msg(), m0);
            chk("bp_ack0", rcv0_ack, 0);
            chk("bp_ack1", rcv1_ack, 0);
        end
        snd0_ack = 1'b1;
        tick();
        chk("cont_sndreq_down", snd0_req, 0);
        m2 = rnd();
        set_rcv(0, m2, 1);
        snd0_ack = 1'b0;
        tick();
        chk("done_no_ack0", rcv0_ack, 0);
        chk("done_no_ack1", rcv1_ack, 0);
        tick();
        chk("rr_ack1", rcv1_ack, 1);
        chk("rr_ack0", rcv0_ack, 0);
        serve(1, m1);
        tick();
        chk("rr_next_ack0", rcv0_ack, 1);
        serve(0, m2);

        // ---- stale snd0_ack while idle / taking
        snd0_ack = 1'b1;
        m3 = rnd();
        set_rcv(1, m3, 1);
        tick();
        chk("stale_ack1", rcv1_ack, 1);
        chk("stale_sndreq", snd0_req, 0);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("stale_hold_ack1", rcv1_ack, 1);
            chk("stale_hold_sndreq", snd0_req, 0);
        end
        snd0_ack = 1'b0;
        tick();
        chk("stale_still_take", rcv1_ack, 1);
        serve(1, m3);

        // ---- reset in the middle of SEND
        m4 = rnd();
        set_rcv(0, m4, 1);
        tick();
        chk("pre_rst_ack0", rcv0_ack, 1);
        serve(0, m4);
        m5 = rnd();
        set_rcv(0, m5, 1);
        tick();
        rcv0_req = 1'b0;
        tick();
        chk("mid_sndreq", snd0_req, 1);
        reset = 1'b1;
        #1;
        chk("mid_rst_sndreq", snd0_req, 0);
        chk("mid_rst_ready", ready, 0);
        chk("mid_rst_fields", snd_msg(), 0);
        chk("mid_rst_ack0", rcv0_ack, 0);
        m6 = rnd();
        m7 = rnd();
        set_rcv(0, m6, 1);
        set_rcv(1, m7, 1);
        tick();
        chk("in_rst_ack0", rcv0_ack, 0);
        chk("in_rst_ack1", rcv1_ack, 0);
        reset = 1'b0;
        tick();
        chk("post_rst_ready", ready, 1);
        chk("post_rst_no_grant0", rcv0_ack, 0);
        chk("post_rst_no_grant1", rcv1_ack, 0);
        tick();
        chk("post_rst_prio_ack0", rcv0_ack, 1);
        chk("post_rst_prio_ack1", rcv1_ack, 0);
        serve(0, m6);
        tick();
        chk("post_rst_ack1", rcv1_ack, 1);
        serve(1, m7);

        // ---- random stream against the arbitration model
        for (int i = 0; i < 100; i++) begin
            if ($urandom_range(1) == 1) q1.push_back(rnd());
            else                        q0.push_back(rnd());
        end
        ph[0] = 0;
        ph[1] = 0;
        cph   = 0;
        mprio = 0;
        busy  = 1'b0;
        outs  = 0;
        cyc   = 0;
        cw    = 0;
        cm    = '0;
        pa0   = rcv0_ack;
        pa1   = rcv1_ack;
        while (outs < 100 && cyc < 20000) begin
            pr0 = rcv0_req;
            pr1 = rcv1_req;
            tick();
            cyc++;
            chk("mutex_ack", rcv0_ack & rcv1_ack, 0);
            chk("mutex_snd", snd0_req & (rcv0_ack | rcv1_ack), 0);
            if ((rcv0_ack && !pa0) || (rcv1_ack && !pa1)) begin
                w = rcv1_ack ? 1 : 0;
                e = (pr0 && pr1) ? mprio : (pr0 ? 0 : (pr1 ? 1 : 2));
                chk("stream_winner", w, e);
                chk("stream_grant_while_busy", busy, 0);
                busy = 1'b1;
                exp_ch.push_back(w);
                exp_m.push_back(cur[w]);
            end
            pa0 = rcv0_ack;
            pa1 = rcv1_ack;
            for (int ch = 0; ch < 2; ch++) begin
                ackc = (ch == 0) ? rcv0_ack : rcv1_ack;
                case (ph[ch])
                    0: begin
                        if ($urandom_range(1) == 1) begin
                            if (ch == 0 && q0.size() > 0) begin
                                cur[0] = q0.pop_front();
                                set_rcv(0, cur[0], 1);
                                ph[0] = 1;
                            end else if (ch == 1 && q1.size() > 0) begin
                                cur[1] = q1.pop_front();
                                set_rcv(1, cur[1], 1);
                                ph[1] = 1;
                            end
                        end
                    end
                    1: begin
                        if (ackc && $urandom_range(1) == 1) begin
                            set_rcv(ch, rnd(), 0);
                            ph[ch] = 2;
                        end
                    end
                    default: begin
                        if (!ackc) ph[ch] = 0;
                    end
                endcase
            end
            case (cph)
                0: begin
                    if (snd0_req) begin
                        if (exp_m.size() == 0) begin
                            chk("stream_spurious_out", snd0_req, 0);
                        end else begin
                            cm = exp_m.pop_front();
                            cw = exp_ch.pop_front();
                            chk("stream_msg", snd_msg(), cm);
                            cph = 1;
                        end
                    end
                end
                1: begin
                    chk("stream_stable_req", snd0_req, 1);
                    chk("stream_stable_msg", snd_msg(), cm);
                    if ($urandom_range(1) == 1) begin
                        snd0_ack = 1'b1;
                        cph = 2;
                    end
                end
                default: begin
                    if (!snd0_req) begin
                        snd0_ack = 1'b0;
                        cph   = 0;
                        mprio = 1 - cw;
                        busy  = 1'b0;
                        outs++;
                    end
                end
            endcase
        end
        chk("stream_count", outs, 100);
        chk("stream_leftover", exp_m.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
